// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side driver: bus addresses,
// driver states and the baud-switch to divisor mapping.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD_RX,
    WAIT_TX,
    WR_TX
  } state_t;

  function automatic logic [15:0] div_sel(
    input logic [1:0]  cfg,
    input logic [15:0] d4800,
    input logic [15:0] d9600,
    input logic [15:0] d19200,
    input logic [15:0] d38400
  );
    logic [15:0] d;
    case (cfg)
      2'b00:   d = d4800;
      2'b01:   d = d9600;
      2'b10:   d = d19200;
      default: d = d38400;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// SPART processor bus: iocs/iorw/ioaddr access strobes plus status and data.
interface spart_driver_if;
  logic       rda;
  logic       tbr;
  logic [7:0] data_in;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    input  rda, tbr, data_in,
    output iocs, iorw, ioaddr, data_out, data_oe
  );

  modport slave (
    output rda, tbr, data_in,
    input  iocs, iorw, ioaddr, data_out, data_oe
  );
endinterface

// File: rtl/spart_driver.sv
// SPART bus-master driver: programs the baud divisor, then echoes received bytes.
// Optional macro SPART_DRV_UPCASE_EN converts lowercase ASCII to uppercase on capture.
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = 16'd1301,
  parameter logic [15:0] DIV_9600  = 16'd650,
  parameter logic [15:0] DIV_19200 = 16'd325,
  parameter logic [15:0] DIV_38400 = 16'd162
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus
);

  state_t      state, next_state;
  logic        run;
  logic [1:0]  cfg_q;
  logic [1:0]  sel_q;
  logic [7:0]  byte_q;
  logic [15:0] div_now, div_sel_q;

  logic       iocs_c, iorw_c, data_oe_c;
  logic [1:0] ioaddr_c;
  logic [7:0] data_out_c;

  function automatic logic [7:0] capture(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return {b[7:6], 1'b0, b[4:0]};
    else                          return b;
`else
    return b;
`endif
  endfunction

  assign div_now   = div_sel(br_cfg, DIV_4800, DIV_9600, DIV_19200, DIV_38400);
  assign div_sel_q = div_sel(sel_q,  DIV_4800, DIV_9600, DIV_19200, DIV_38400);

  // run holds the bus quiet for the first cycle after reset so outputs
  // show their reset values before the first divisor write
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CFG_LO;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q  <= 2'b00;
      sel_q  <= 2'b00;
      byte_q <= 8'h00;
    end else if (run) begin
      case (state)
        CFG_LO:  sel_q  <= br_cfg;
        CFG_HI:  cfg_q  <= br_cfg;
        RD_RX:   byte_q <= capture(bus.data_in);
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CFG_LO:  next_state = CFG_HI;
      CFG_HI:  next_state = IDLE;
      IDLE: begin
        if (br_cfg != cfg_q) next_state = CFG_LO;
        else if (bus.rda)    next_state = RD_RX;
      end
      RD_RX:   next_state = WAIT_TX;
      WAIT_TX: if (bus.tbr) next_state = WR_TX;
      WR_TX:   next_state = IDLE;
      default: next_state = CFG_LO;
    endcase
  end

  always_comb begin
    iocs_c     = 1'b0;
    iorw_c     = 1'b1;
    ioaddr_c   = ADDR_BUF;
    data_out_c = 8'h00;
    data_oe_c  = 1'b0;
    if (run) begin
      case (state)
        CFG_LO: begin
          iocs_c = 1'b1; iorw_c = 1'b0; data_oe_c = 1'b1;
          ioaddr_c = ADDR_DBL; data_out_c = div_now[7:0];
        end
        CFG_HI: begin
          iocs_c = 1'b1; iorw_c = 1'b0; data_oe_c = 1'b1;
          ioaddr_c = ADDR_DBH; data_out_c = div_sel_q[15:8];
        end
        RD_RX: begin
          iocs_c = 1'b1; ioaddr_c = ADDR_BUF;
        end
        WR_TX: begin
          iocs_c = 1'b1; iorw_c = 1'b0; data_oe_c = 1'b1;
          ioaddr_c = ADDR_BUF; data_out_c = byte_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.iocs     = iocs_c;
  assign bus.iorw     = iorw_c;
  assign bus.ioaddr   = ioaddr_c;
  assign bus.data_out = data_out_c;
  assign bus.data_oe  = data_oe_c;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: directed literal scenarios plus randomized traffic
// checked every cycle against a queue-of-bus-actions reference model.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  int         checks = 0;
  int         errors = 0;

  spart_driver_if bus();

  spart_driver dut (
    .clk   (clk),
    .rst   (rst),
    .br_cfg(br_cfg),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mdiv(input logic [1:0] c);
    case (c)
      2'd0:    return 16'd1301;
      2'd1:    return 16'd650;
      2'd2:    return 16'd325;
      default: return 16'd162;
    endcase
  endfunction

  function automatic logic [7:0] mconv(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  // reference model: a script of pending bus actions; empty script = idle decision cycle
  localparam int A_NOP = 0, A_LO = 1, A_HI = 2, A_RD = 3, A_WAIT = 4, A_WR = 5;
  int         q[$];
  logic [1:0] m_cfg, m_sel;
  logic [7:0] m_byte;
  bit         m_valid = 1'b0;
  logic       e_cs, e_rw, e_oe;
  logic [1:0] e_addr;
  logic [7:0] e_do;

  always @(negedge clk) begin
    if (m_valid) begin
      e_cs = 1'b0; e_rw = 1'b1; e_addr = 2'd0; e_do = 8'h00; e_oe = 1'b0;
      if (q.size() == 0) begin
        if (br_cfg != m_cfg) begin
          q.push_back(A_LO); q.push_back(A_HI);
        end else if (bus.rda) begin
          q.push_back(A_RD); q.push_back(A_WAIT); q.push_back(A_WR);
        end
      end else begin
        case (q[0])
          A_LO: begin
            e_cs = 1'b1; e_rw = 1'b0; e_oe = 1'b1; e_addr = 2'd2;
            e_do = mdiv(br_cfg) % 256; m_sel = br_cfg;
          end
          A_HI: begin
            e_cs = 1'b1; e_rw = 1'b0; e_oe = 1'b1; e_addr = 2'd3;
            e_do = mdiv(m_sel) / 256; m_cfg = br_cfg;
          end
          A_RD: begin
            e_cs = 1'b1; m_byte = mconv(bus.data_in);
          end
          A_WR: begin
            e_cs = 1'b1; e_rw = 1'b0; e_oe = 1'b1; e_do = m_byte;
          end
          default: ;
        endcase
        if (q[0] != A_WAIT || bus.tbr) void'(q.pop_front());
      end
      chk("bus_cycle", {19'd0, bus.iocs, bus.iorw, bus.ioaddr, bus.data_out, bus.data_oe},
          {19'd0, e_cs, e_rw, e_addr, e_do, e_oe});
    end
    if (rst) begin
      q.delete();
      q.push_back(A_NOP); q.push_back(A_LO); q.push_back(A_HI);
      m_byte  = 8'h00;
      m_valid = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_acc(input string name, input bit wr, input logic [1:0] addr,
                            input logic [7:0] d, input int maxc, output int lat);
    bit found = 1'b0;
    lat = 0;
    while (!found && lat < maxc) begin
      @(negedge clk);
      lat++;
      if (bus.iocs === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: no access within %0d cycles", name, maxc);
    end else begin
      chk({name, "_rw"},   bus.iorw, !wr);
      chk({name, "_addr"}, bus.ioaddr, addr);
      chk({name, "_oe"},   bus.data_oe, wr);
      if (wr) chk({name, "_data"}, bus.data_out, d);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    @(negedge clk);
    chk({name, "_iocs"},  bus.iocs, 1'b0);
    chk({name, "_iorw"},  bus.iorw, 1'b1);
    chk({name, "_addr"},  bus.ioaddr, 2'd0);
    chk({name, "_dout"},  bus.data_out, 8'h00);
    chk({name, "_oe"},    bus.data_oe, 1'b0);
  endtask

  task automatic echo(input string name, input logic [7:0] din, input logic [7:0] dexp);
    int lat;
    bus.rda = 1'b1; bus.tbr = 1'b1; bus.data_in = din;
    expect_acc({name, "_rd"}, 1'b0, 2'd0, 8'h00, 3, lat);
    chk({name, "_rd_lat"}, lat, 2);
    step(); bus.rda = 1'b0;
    expect_acc({name, "_wr"}, 1'b1, 2'd0, dexp, 3, lat);
    chk({name, "_wr_lat"}, lat, 2);
    step();
  endtask

  initial begin
    int lat, n;
    rst = 1'b1; br_cfg = 2'b01;
    bus.rda = 1'b0; bus.tbr = 1'b0; bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    step(); rst = 1'b0;
    expect_acc("cfg_lo", 1'b1, 2'd2, 8'h8A, 3, lat);
    chk("cfg_lo_lat", lat, 2);
    expect_acc("cfg_hi", 1'b1, 2'd3, 8'h02, 1, lat);
    @(negedge clk);
    chk("idle_after_cfg", bus.iocs, 1'b0);
    step();

    echo("e41", 8'h41, 8'h41);

    bus.rda = 1'b1; bus.tbr = 1'b0; bus.data_in = 8'h5A;
    expect_acc("h5a_rd", 1'b0, 2'd0, 8'h00, 3, lat);
    step(); bus.rda = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.iocs === 1'b1) n++;
    end
    chk("hold_quiet", n, 0);
    step(); bus.tbr = 1'b1;
    expect_acc("h5a_wr", 1'b1, 2'd0, 8'h5A, 3, lat);
    chk("h5a_wr_lat", lat, 2);
    step();

    bus.rda = 1'b1; bus.tbr = 1'b0; bus.data_in = 8'h33;
    expect_acc("rc_rd", 1'b0, 2'd0, 8'h00, 3, lat);
    step(); bus.rda = 1'b0;
    repeat (3) step();
    br_cfg = 2'b11;
    repeat (3) step();
    bus.tbr = 1'b1;
    expect_acc("rc_wr", 1'b1, 2'd0, 8'h33, 2, lat);
    expect_acc("rc_lo", 1'b1, 2'd2, 8'hA2, 2, lat);
    chk("rc_lo_lat", lat, 2);
    expect_acc("rc_hi", 1'b1, 2'd3, 8'h00, 1, lat);
    step();

    br_cfg = 2'b10; bus.rda = 1'b1; bus.data_in = 8'h77;
    expect_acc("pri_lo", 1'b1, 2'd2, 8'h45, 3, lat);
    chk("pri_lo_lat", lat, 2);
    expect_acc("pri_hi", 1'b1, 2'd3, 8'h01, 1, lat);
    expect_acc("pri_rd", 1'b0, 2'd0, 8'h00, 2, lat);
    chk("pri_rd_lat", lat, 2);
    step(); bus.rda = 1'b0;
    expect_acc("pri_wr", 1'b1, 2'd0, 8'h77, 3, lat);
    step();

    br_cfg = 2'b01;
    expect_acc("rh_lo", 1'b1, 2'd2, 8'h8A, 3, lat);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk_reset_vals("rst_hi");
    expect_acc("rh_lo2", 1'b1, 2'd2, 8'h8A, 2, lat);
    chk("rh_lo2_lat", lat, 1);
    expect_acc("rh_hi2", 1'b1, 2'd3, 8'h02, 1, lat);
    step();

`ifdef SPART_DRV_UPCASE_EN
    echo("e61", 8'h61, 8'h41);
`else
    echo("e61", 8'h61, 8'h61);
`endif
    echo("e7b", 8'h7B, 8'h7B);

    repeat (3000) begin
      step();
      rst         = ($urandom_range(0, 299) == 0);
      bus.rda     = ($urandom_range(0, 3) == 0);
      bus.tbr     = ($urandom_range(0, 2) != 0);
      bus.data_in = 8'($urandom);
      if ($urandom_range(0, 99) == 0) br_cfg = 2'($urandom);
    end
    step(); rst = 1'b0; bus.rda = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
Bus-master driver on the processor side of the SPART, acting as the initiator of iocs/iorw/ioaddr transactions that the transmit/receive datapath answers.
- After reset, programs the baud divisor selected by the board switches.
- Then runs a polled echo loop: waits for a received byte, reads it, waits for the transmitter, and writes the byte back.
- Sits at top level between the switch inputs and the SPART bus port.

Parameters:
- DIV_4800, 1301, divisor loaded when br_cfg=2'b00
- DIV_9600, 650, divisor loaded when br_cfg=2'b01
- DIV_19200, 325, divisor loaded when br_cfg=2'b10
- DIV_38400, 162, divisor loaded when br_cfg=2'b11

Ports:
- clk  input  1  system clock, single clock domain
- rst  input  1  synchronous, active-high reset
- br_cfg  input  2  baud select switches
- rda  input  1  receive data available from SPART
- tbr  input  1  transmit buffer ready from SPART
- data_in  input  8  bus read data, valid in the same cycle as a read access
- iocs  output  1  chip select, one-cycle strobe per access
- iorw  output  1  1 = read, 0 = write; only meaningful while iocs=1
- ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = divisor low, 11 = divisor high
- data_out  output  8  bus write data
- data_oe  output  1  drives the top-level tristate databus; high only during write accesses

Behaviour:
- Reset values of every output: iocs=0, iorw=1, ioaddr=00, data_out=0, data_oe=0. Internal byte register resets to 0. State resets to CFG_LO.
- Every bus access lasts exactly one cycle (iocs=1). Between accesses iocs=0 and data_oe=0.
- On a write access: iorw=0, data_oe=1, data_out is valid. On a read access: iorw=1, data_oe=0, data_in is sampled in that same cycle.
- Divisor width: 16 bits, selected by br_cfg (sampled in CFG_LO). CFG_LO writes divisor[7:0] to ioaddr 10; CFG_HI writes divisor[15:8] to ioaddr 11.
- States and transitions:
  - CFG_LO: write low divisor byte -> CFG_HI.
  - CFG_HI: write high divisor byte; latch br_cfg into cfg_q -> IDLE.
  - IDLE: no access.
    - If br_cfg != cfg_q -> CFG_LO. Reconfiguration has priority over a pending rda.
    - Else if rda=1 -> RD_RX.
  - RD_RX: read ioaddr 00; capture data_in into the byte register -> WAIT_TX.
  - WAIT_TX: no access; stay while tbr=0; when tbr=1 -> WR_TX.
  - WR_TX: write the byte register to ioaddr 00 -> IDLE.
- Latency: IDLE with rda=1 at cycle N gives the read at N+1. With tbr already 1, the write occurs at N+3.
- rda is checked only in IDLE. A byte arriving during configuration or during WAIT_TX is served on the next IDLE visit. The driver never issues two reads without an intervening write.
- br_cfg changes outside IDLE are deferred until the next IDLE.
- tbr staying low forever leaves the FSM in WAIT_TX with no bus activity; there is no timeout.
- rst asserted in any state, including mid-access, returns all outputs to reset values on the next edge and restarts configuration. A partially written divisor is rewritten.

Optional Feature:
- Macro: SPART_DRV_UPCASE_EN.
- Defined: a byte in 8'h61..8'h7A is echoed with bit 5 cleared (lowercase -> uppercase). The conversion is applied when capturing in RD_RX; all other bytes pass unchanged.
- Not defined: bytes are echoed unmodified.
- Timing and state sequence are identical in both builds.

Decomposition:
- Shared package spart_pkg holds:
  - ioaddr constants ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11
  - the state enum {CFG_LO, CFG_HI, IDLE, RD_RX, WAIT_TX, WR_TX}
  - a function mapping br_cfg to the 16-bit divisor, taking the four parameters as arguments
- No sub-module is warranted; the block is a single FSM plus a byte register.

Test Plan:
- Reset release with br_cfg=01 -> cycle 1: iocs=1, iorw=0, ioaddr=10, data_out=8'h8A. Cycle 2: ioaddr=11, data_out=8'h02. Then idle with iocs=0.
- After configuration, pulse rda with data_in=8'h41 and tbr=1 -> one read at ioaddr 00, then two cycles later one write of 8'h41 at ioaddr 00 with data_oe=1.
- rda with byte 8'h5A, tbr held 0 for 20 cycles -> no bus access during the hold. Write of 8'h5A occurs one cycle after tbr rises.
- br_cfg changes 01->11 while in WAIT_TX -> echo write completes first, then divisor writes of 8'hA2 and 8'h00. Changing br_cfg and asserting rda together in IDLE -> configuration writes precede the read.
- rst asserted for one cycle in CFG_HI -> outputs return to reset values and the sequence restarts with the ioaddr 10 write.
- Echo 8'h61 -> 8'h41 with SPART_DRV_UPCASE_EN defined, 8'h61 without it. 8'h7B is unchanged in both builds.
